// File: rtl/skein_pkg.sv
// Shared definitions for the Threefish word-permutation datapath.
//   nw_sel_e      : encoding of the active word count carried with each state
//   skid_state_e  : occupancy of the 2-entry output skid buffer
//   PI*_FWD/INV   : forward and inverse pi tables (out word i = in word pi(i))
//   nw_words()    : word count selected by an nw_sel code (0 for illegal)
//   nw_sel_illegal(): nw_sel is the illegal code or exceeds the build's NW_MAX
package skein_pkg;

  typedef enum logic [1:0] {
    NW4        = 2'd0,
    NW8        = 2'd1,
    NW16       = 2'd2,
    NW_ILLEGAL = 2'd3
  } nw_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam logic [3:0] PI4_FWD [4] = '{4'd0, 4'd3, 4'd2, 4'd1};
  localparam logic [3:0] PI4_INV [4] = '{4'd0, 4'd3, 4'd2, 4'd1};

  localparam logic [3:0] PI8_FWD [8] = '{4'd2, 4'd1, 4'd4, 4'd7,
                                         4'd6, 4'd5, 4'd0, 4'd3};
  localparam logic [3:0] PI8_INV [8] = '{4'd6, 4'd1, 4'd0, 4'd7,
                                         4'd2, 4'd5, 4'd4, 4'd3};

  localparam logic [3:0] PI16_FWD [16] = '{4'd0,  4'd9,  4'd2,  4'd13,
                                           4'd6,  4'd11, 4'd4,  4'd15,
                                           4'd10, 4'd7,  4'd12, 4'd3,
                                           4'd14, 4'd5,  4'd8,  4'd1};
  localparam logic [3:0] PI16_INV [16] = '{4'd0,  4'd15, 4'd2,  4'd11,
                                           4'd6,  4'd13, 4'd4,  4'd9,
                                           4'd14, 4'd1,  4'd8,  4'd5,
                                           4'd12, 4'd3,  4'd10, 4'd7};

  function automatic int unsigned nw_words(input logic [1:0] sel);
    int unsigned n;
    case (sel)
      2'd0:    n = 4;
      2'd1:    n = 8;
      2'd2:    n = 16;
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic logic nw_sel_illegal(input logic [1:0] sel,
                                          input int unsigned nw_max);
    return (nw_words(sel) == 0) || (nw_words(sel) > nw_max);
  endfunction

endpackage

// File: rtl/threefish_pi_lut.sv
// Combinational pi lookup for a single output word position.
//   nw_sel_i : active word count code
//   inv_i    : 0 = forward pi, 1 = inverse pi
//   idx_i    : output word index this lookup serves
//   src_o    : input word index feeding this output word
//   zero_o   : 1 when this output word must be forced to zero (index beyond
//              the active count, illegal code, or count above NW_MAX)
module threefish_pi_lut
  import skein_pkg::*;
#(
  parameter int unsigned NW_MAX = 16
) (
  input  logic [1:0] nw_sel_i,
  input  logic       inv_i,
  input  logic [3:0] idx_i,
  output logic [3:0] src_o,
  output logic       zero_o
);

  always_comb begin
    src_o  = '0;
    zero_o = 1'b1;
    if (!nw_sel_illegal(nw_sel_i, NW_MAX) &&
        ({28'd0, idx_i} < nw_words(nw_sel_i))) begin
      zero_o = 1'b0;
      case (nw_sel_e'(nw_sel_i))
        NW4:     src_o = inv_i ? PI4_INV[idx_i[1:0]]  : PI4_FWD[idx_i[1:0]];
        NW8:     src_o = inv_i ? PI8_INV[idx_i[2:0]]  : PI8_FWD[idx_i[2:0]];
        NW16:    src_o = inv_i ? PI16_INV[idx_i]      : PI16_FWD[idx_i];
        default: zero_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/threefish_permute_unit.sv
// Threefish pi word permutation with a 2-entry output skid buffer.
//   clk_i, rst_n_i         : clock, synchronous active-low reset
//   in_valid_i/in_ready_o  : input handshake (in_ready_o is registered)
//   in_state_i             : NW_MAX words, word k at [k*WW +: WW]
//   nw_sel_i, inv_i        : word count code and direction, sampled with data
//   out_valid_o/out_ready_i: output handshake
//   out_state_o, out_err_o : permuted state and illegal-nw_sel flag
//   perm_count_o           : wrapping count of completed output transfers
module threefish_permute_unit
  import skein_pkg::*;
#(
  parameter int unsigned WW     = 64,
  parameter int unsigned NW_MAX = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NW_MAX*WW-1:0] in_state_i,
  input  logic [1:0]           nw_sel_i,
  input  logic                 inv_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NW_MAX*WW-1:0] out_state_o,
  output logic                 out_err_o,
  output logic [31:0]          perm_count_o
);

  logic [NW_MAX-1:0][3:0]    src_w;
  logic [NW_MAX-1:0]         zero_w;
  logic [NW_MAX*WW-1:0]      perm_d;
  logic                      err_d;

  skid_state_e               state_q;
  logic [NW_MAX*WW-1:0]      head_q;
  logic [NW_MAX*WW-1:0]      tail_q;
  logic                      head_err_q;
  logic                      tail_err_q;
  logic                      out_valid_q;
  logic                      in_ready_q;
  logic [31:0]               count_q;

  logic                      in_xfer;
  logic                      out_xfer;

  for (genvar k = 0; k < NW_MAX; k++) begin : g_lut
    threefish_pi_lut #(
      .NW_MAX (NW_MAX)
    ) u_lut (
      .nw_sel_i (nw_sel_i),
      .inv_i    (inv_i),
      .idx_i    (4'(k)),
      .src_o    (src_w[k]),
      .zero_o   (zero_w[k])
    );
  end

  // Each output word is a one-hot mux over the input words, selected by its
  // LUT; forced-zero words match no source and stay at zero.
  always_comb begin
    perm_d = '0;
    for (int unsigned k = 0; k < NW_MAX; k++) begin
      for (int unsigned j = 0; j < NW_MAX; j++) begin
        if (!zero_w[k] && (src_w[k] == 4'(j))) begin
          perm_d[k*WW +: WW] = in_state_i[j*WW +: WW];
        end
      end
    end
  end

  assign err_d    = nw_sel_illegal(nw_sel_i, NW_MAX);
  assign in_xfer  = in_valid_i & in_ready_q;
  assign out_xfer = out_valid_q & out_ready_i;

  // head_q always drives the output; tail_q only holds the second entry in TWO.
  // in_ready is decided from next-state occupancy so it stays a pure register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      head_err_q  <= 1'b0;
      tail_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      if (out_xfer) begin
        count_q <= count_q + 32'd1;
      end
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            head_q      <= perm_d;
            head_err_q  <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          in_ready_q <= 1'b1;
          if (in_xfer && !out_xfer) begin
            tail_q     <= perm_d;
            tail_err_q <= err_d;
            in_ready_q <= 1'b0;
            state_q    <= TWO;
          end else if (!in_xfer && out_xfer) begin
            out_valid_q <= 1'b0;
            head_err_q  <= 1'b0;
            state_q     <= EMPTY;
          end else if (in_xfer && out_xfer) begin
            head_q     <= perm_d;
            head_err_q <= err_d;
          end
        end
        TWO: begin
          if (out_xfer) begin
            head_q     <= tail_q;
            head_err_q <= tail_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_state_o  = head_q;
  assign out_err_o    = head_err_q;
  assign perm_count_o = count_q;

endmodule

// File: tb/tb_threefish_permute_unit.sv
module tb_threefish_permute_unit;

  localparam int WW = 64;
  localparam int NWM = 16;
  localparam int SW = WW * NWM;

  localparam int FWD4 [4]   = '{0, 3, 2, 1};
  localparam int INV4 [4]   = '{0, 3, 2, 1};
  localparam int FWD8 [8]   = '{2, 1, 4, 7, 6, 5, 0, 3};
  localparam int INV8 [8]   = '{6, 1, 0, 7, 2, 5, 4, 3};
  localparam int FWD16 [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};
  localparam int INV16 [16] = '{0, 15, 2, 11, 6, 13, 4, 9, 14, 1, 8, 5, 12, 3, 10, 7};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_state;
  logic [1:0]    nw_sel;
  logic          inv;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic          out_err;
  logic [31:0]   perm_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  threefish_permute_unit #(
    .WW     (WW),
    .NW_MAX (NWM)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_state_i   (in_state),
    .nw_sel_i     (nw_sel),
    .inv_i        (inv),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_state_o  (out_state),
    .out_err_o    (out_err),
    .perm_count_o (perm_count)
  );

  // word k = base + k for the first n words, zero above
  function automatic logic [SW-1:0] mk(input int base, input int n);
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*WW +: WW] = 64'(base + k);
    return v;
  endfunction

  function automatic logic [SW-1:0] perm(input logic [SW-1:0] s, input int n, input bit iv);
    logic [SW-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (n == 4)      src = iv ? INV4[i]  : FWD4[i];
      else if (n == 8) src = iv ? INV8[i]  : FWD8[i];
      else             src = iv ? INV16[i] : FWD16[i];
      r[i*WW +: WW] = s[src*WW +: WW];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [SW-1:0] exp);
    for (int w = 0; w < NWM; w++)
      check($sformatf("%s w%0d", tag, w), out_state[w*WW +: WW], exp[w*WW +: WW]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] saved;
  logic [SW-1:0] pa, pb, pc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_state  = mk(32'h5555, 16);
    nw_sel    = 2'd2;
    inv       = 1'b0;
    out_ready = 1'b1;

    // reset with inputs offered: nothing accepted
    step(); step(); step();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst count", 64'(perm_count), 64'd0);
    check("rst err", 64'(out_err), 64'd0);
    check_state("rst state", '0);

    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("post-rst in_ready", 64'(in_ready), 64'd1);
    check("post-rst out_valid", 64'(out_valid), 64'd0);

    // NW=16 forward, identity input
    in_valid = 1'b1; in_state = mk(0, 16); nw_sel = 2'd2; inv = 1'b0;
    step();
    in_valid = 1'b0;
    check("nw16 valid", 64'(out_valid), 64'd1);
    check("nw16 err", 64'(out_err), 64'd0);
    check_state("nw16 fwd", perm(mk(0, 16), 16, 1'b0));
    check("nw16 w3 literal", out_state[3*WW +: WW], 64'd13);
    step();
    check("nw16 drained", 64'(out_valid), 64'd0);
    check("count 1", 64'(perm_count), 64'd1);

    // NW=8 forward then inverse round trip
    in_valid = 1'b1; in_state = mk(0, 16); nw_sel = 2'd1; inv = 1'b0;
    step();
    in_valid = 1'b0;
    check_state("nw8 fwd", perm(mk(0, 16), 8, 1'b0));
    check("nw8 w3 literal", out_state[3*WW +: WW], 64'd7);
    saved = out_state;
    step();
    in_valid = 1'b1; in_state = saved; nw_sel = 2'd1; inv = 1'b1;
    step();
    in_valid = 1'b0;
    check_state("nw8 inv", mk(0, 8));
    step();

    // NW=4 forward
    in_valid = 1'b1; in_state = mk(0, 16); nw_sel = 2'd0; inv = 1'b0;
    step();
    in_valid = 1'b0;
    check_state("nw4 fwd", perm(mk(0, 16), 4, 1'b0));
    step();
    check("count 4", 64'(perm_count), 64'd4);

    // illegal nw_sel
    in_valid = 1'b1; in_state = {16{64'hDEAD_BEEF_0123_4567}}; nw_sel = 2'd3; inv = 1'b0;
    step();
    in_valid = 1'b0;
    check("ill valid", 64'(out_valid), 64'd1);
    check("ill err", 64'(out_err), 64'd1);
    check_state("ill state", '0);
    step();
    check("ill count", 64'(perm_count), 64'd5);
    check("ill drained", 64'(out_valid), 64'd0);

    // backpressure: A, B accepted, C held
    pa = perm(mk(32'hA00, 16), 16, 1'b0);
    pb = perm(mk(32'hB00, 16), 16, 1'b0);
    pc = perm(mk(32'hC00, 16), 16, 1'b0);
    out_ready = 1'b0; nw_sel = 2'd2; inv = 1'b0;
    in_valid = 1'b1; in_state = mk(32'hA00, 16);
    step();
    check("bp A ready", 64'(in_ready), 64'd1);
    check("bp A valid", 64'(out_valid), 64'd1);
    check_state("bp A head", pa);
    in_state = mk(32'hB00, 16);
    step();
    check("bp B ready", 64'(in_ready), 64'd0);
    check_state("bp B head", pa);
    in_state = mk(32'hC00, 16);
    step();
    check("bp C ready", 64'(in_ready), 64'd0);
    check("bp C valid", 64'(out_valid), 64'd1);
    check_state("bp C head", pa);
    step();
    check_state("bp hold head", pa);
    out_ready = 1'b1;
    step();
    check("bp out B valid", 64'(out_valid), 64'd1);
    check_state("bp out B", pb);
    step();
    in_valid = 1'b0;
    check("bp out C valid", 64'(out_valid), 64'd1);
    check_state("bp out C", pc);
    step();
    check("bp drained", 64'(out_valid), 64'd0);
    check("bp count", 64'(perm_count), 64'd8);

    // fresh reset, then 100 back-to-back states
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1; nw_sel = 2'd2; inv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_state = mk(i * 16, 16);
      step();
      check($sformatf("b2b %0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("b2b %0d ready", i), 64'(in_ready), 64'd1);
      check($sformatf("b2b %0d w1", i), out_state[1*WW +: WW], 64'(i * 16 + 9));
      check($sformatf("b2b %0d w15", i), out_state[15*WW +: WW], 64'(i * 16 + 1));
    end
    in_valid = 1'b0;
    step();
    check("b2b drained", 64'(out_valid), 64'd0);
    check("b2b count", 64'(perm_count), 64'd100);

    // reset while buffer is full
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = mk(32'hD00, 16);
    step();
    in_state = mk(32'hE00, 16);
    step();
    check("full ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0; in_state = mk(32'hF00, 16);
    step();
    check("mid-rst valid", 64'(out_valid), 64'd0);
    check("mid-rst count", 64'(perm_count), 64'd0);
    check("mid-rst ready", 64'(in_ready), 64'd0);
    check_state("mid-rst state", '0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post-rst idle %0d", i), 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1; in_state = mk(32'h700, 16);
    step();
    in_valid = 1'b0;
    check_state("post-rst new", perm(mk(32'h700, 16), 16, 1'b0));
    step();
    check("post-rst count", 64'(perm_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/threefish_permute_unit.md
THREEFISH_PERMUTE_UNIT -- requirements
Module: threefish_permute_unit

Interface
REQ-001 The block SHALL have parameter WW, default 64, meaning the word width in bits.
REQ-002 The block SHALL have parameter NW_MAX, default 16, meaning the maximum state words; legal values are 4, 8 and 16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port in_valid_i, input, 1 bit: the input state is valid.
REQ-006 The block SHALL have port in_ready_o, output, 1 bit: the block can accept an input state.
REQ-007 The block SHALL have port in_state_i, input, NW_MAX*WW bits: the input state, with word k at bits [k*WW +: WW].
REQ-008 The block SHALL have port nw_sel_i, input, 2 bits: the active word count, 0=4 words, 1=8 words, 2=16 words, 3=illegal; sampled with in_state_i.
REQ-009 The block SHALL have port inv_i, input, 1 bit: 0 applies the forward pi permutation, 1 applies the inverse pi permutation; sampled with in_state_i.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: the output state is valid.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts the output state.
REQ-012 The block SHALL have port out_state_o, output, NW_MAX*WW bits: the permuted state.
REQ-013 The block SHALL have port out_err_o, output, 1 bit: the output entry carried an illegal or out-of-range nw_sel.
REQ-014 The block SHALL have port perm_count_o, output, 32 bits: the count of completed output transfers.

Function
REQ-015 The block SHALL apply the permutation out word i = in word pi(i) for i < NW, where NW is the active word count.
REQ-016 The forward tables SHALL be: NW=4: 0,3,2,1; NW=8: 2,1,4,7,6,5,0,3; NW=16: 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1.
REQ-017 The inverse tables SHALL be: NW=4: 0,3,2,1; NW=8: 6,1,0,7,2,5,4,3; NW=16: 0,15,2,11,6,13,4,9,14,1,8,5,12,3,10,7.
REQ-018 Output words with index >= NW SHALL be zero.
REQ-019 If nw_sel_i is 3, or selects a word count greater than NW_MAX, the entry SHALL carry out_err_o=1 with all output words zero; the entry is still transferred normally.
REQ-020 An input transfer SHALL occur on a clock edge where in_valid_i and in_ready_o are both 1; an output transfer SHALL occur on a clock edge where out_valid_o and out_ready_i are both 1.
REQ-021 The permutation SHALL be computed combinationally from in_state_i and registered on acceptance; latency is 1 cycle from input transfer to out_valid_o=1 when the buffer was empty.
REQ-022 Buffering SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-023 Skid buffer transitions SHALL be: EMPTY -> ONE on an input transfer.
REQ-024 Skid buffer transitions SHALL be: ONE -> TWO on an input transfer without an output transfer.
REQ-025 Skid buffer transitions SHALL be: ONE -> EMPTY on an output transfer without an input transfer.
REQ-026 Skid buffer transitions SHALL be: ONE -> ONE on a simultaneous input and output transfer.
REQ-027 Skid buffer transitions SHALL be: TWO -> ONE on an output transfer.
REQ-028 in_ready_o SHALL be 1 exactly when the state is not TWO and SHALL be a registered signal with no combinational path from out_ready_i.
REQ-029 Ordering SHALL be FIFO: out_state_o, out_err_o and out_valid_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-030 Sustained throughput SHALL be 1 state per cycle when out_ready_i is held at 1.
REQ-031 perm_count_o SHALL increment by 1 on each output transfer and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 While rst_n_i=0 at a clock edge, the buffer SHALL go to EMPTY and both entries SHALL be discarded, including mid-operation.
REQ-033 While rst_n_i=0 at a clock edge, out_valid_o, out_err_o, out_state_o and perm_count_o SHALL be set to 0.
REQ-034 While rst_n_i=0 at a clock edge, in_ready_o SHALL be set to 0; in_ready_o SHALL be 1 from the first edge with rst_n_i=1.
REQ-035 Inputs presented during reset SHALL be ignored.

Structure
REQ-036 Package skein_pkg SHALL hold the forward and inverse pi tables and the nw_sel encodings (NW4, NW8, NW16, NW_ILLEGAL).
REQ-037 A sub-module threefish_pi_lut SHALL be combinational, take nw_sel, inv and an output word index, and return a source index plus a zero flag; the block SHALL instantiate one per output word.

Verification
REQ-038 The bench SHALL cover: in word k = k, nw_sel=2, inv=0 -> out words 0..15 = 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1, out_err_o=0, out_valid_o=1 one cycle after transfer.
REQ-039 The bench SHALL cover: in word k = k, nw_sel=1, inv=0 -> out words 0..7 = 2,1,4,7,6,5,0,3 and out words 8..15 = 0; then feeding that output back with inv=1 -> out words 0..7 = 0..7.
REQ-040 The bench SHALL cover: nw_sel=3 with arbitrary data -> out_err_o=1, out_state_o all zero, perm_count_o increments on transfer.
REQ-041 The bench SHALL cover: out_ready_i=0 while three states A,B,C are offered -> A and B accepted, in_ready_o=0 after B, C held; then out_ready_i=1 -> A, B, C delivered in order with no loss or duplication.
REQ-042 The bench SHALL cover: 100 back-to-back states with out_ready_i=1 -> one output per cycle and perm_count_o=100.
REQ-043 The bench SHALL cover: reset asserted with the buffer in state TWO -> next cycle out_valid_o=0 and perm_count_o=0, and no pre-reset data ever appears on the output.
